// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler slice.
// Holds ALU interface widths, opcode encodings and the scheduler state encoding.
// No ports: imported by alu_req_scheduler and rr_arbiter.
package alu_pkg;

    localparam int INST_W    = 4;
    localparam int DATA_W    = 16;
    localparam int MAT_BEATS = 8;

    localparam logic [INST_W-1:0] OP_ADD    = 4'd0;
    localparam logic [INST_W-1:0] OP_SUB    = 4'd1;
    localparam logic [INST_W-1:0] OP_MAC    = 4'd2;
    localparam logic [INST_W-1:0] OP_TAYLOR = 4'd3;
    localparam logic [INST_W-1:0] OP_GRAY   = 4'd4;
    localparam logic [INST_W-1:0] OP_CPOP   = 4'd5;
    localparam logic [INST_W-1:0] OP_ROR    = 4'd6;
    localparam logic [INST_W-1:0] OP_CLZ    = 4'd7;
    localparam logic [INST_W-1:0] OP_MATCH  = 4'd8;
    localparam logic [INST_W-1:0] OP_MAT    = 4'd9;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N_REQ.
// Purely combinational.
// Ports:
//   req      in   N_REQ  request mask
//   ptr      in   IDX_W  highest-priority index this round
//   gnt_vld  out  1      some request was asserted
//   gnt_idx  out  IDX_W  index of the chosen request (0 when none)
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);
    import alu_pkg::*;

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one fixed-point ALU between N_REQ command sources. Round-robin
// arbitration, one operation in flight, matrix loads (OP_MAT) locked to one
// requester for MAT_BEATS beats, every result returned tagged with the issuer.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid/o_req_ready      per-requester handshake (N_REQ each)
//   i_req_inst/data_a/data_b     packed per-requester command fields
//   o_alu_in_valid/inst/data_*   command to the ALU
//   i_alu_busy/out_valid/data    ALU status and result
//   o_rsp_valid/id/data/last     tagged result stream, no backpressure
//   i_mac_release                (ALU_SCHED_MAC_LOCK_EN only) per-requester MAC release
//
// Build option ALU_SCHED_MAC_LOCK_EN: lock the ALU's MAC accumulator to the
// first requester that issues OP_MAC until that requester releases it.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_ARB   | no operation owned; pick a requester round-robin
// ST_ISSUE | feeding the granted requester's beat(s) to the ALU
// ST_WAIT  | collecting results; last one returns to ST_ARB
module alu_req_scheduler #(
    parameter int N_REQ     = 2,
    parameter int ID_W      = 3,
    parameter int INST_W    = alu_pkg::INST_W,
    parameter int DATA_W    = alu_pkg::DATA_W,
    parameter int MAT_BEATS = alu_pkg::MAT_BEATS
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req_valid,
    output logic [N_REQ-1:0]        o_req_ready,
    input  logic [N_REQ*INST_W-1:0] i_req_inst,
    input  logic [N_REQ*DATA_W-1:0] i_req_data_a,
    input  logic [N_REQ*DATA_W-1:0] i_req_data_b,
`ifdef ALU_SCHED_MAC_LOCK_EN
    input  logic [N_REQ-1:0]        i_mac_release,
`endif
    output logic                    o_alu_in_valid,
    output logic [INST_W-1:0]       o_alu_inst,
    output logic [DATA_W-1:0]       o_alu_data_a,
    output logic [DATA_W-1:0]       o_alu_data_b,
    input  logic                    i_alu_busy,
    input  logic                    i_alu_out_valid,
    input  logic [DATA_W-1:0]       i_alu_data,
    output logic                    o_rsp_valid,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [DATA_W-1:0]       o_rsp_data,
    output logic                    o_rsp_last
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(MAT_BEATS + 1);

    sched_state_t      state, state_nxt;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_ptr;
    // beat_left: matrix beats still to accept after the first (0 = next beat is a first beat)
    logic [CNT_W-1:0]  beat_left;
    logic [CNT_W-1:0]  rsp_left;

    logic [N_REQ-1:0]  arb_req;
    logic              arb_vld;
    logic [ID_W-1:0]   arb_idx;

    logic              sel_valid;
    logic [INST_W-1:0] sel_inst;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              beat_fire;
    logic              rsp_fire;
    logic              rsp_is_last;

    always_comb begin
        sel_valid = 1'b0;
        sel_inst  = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (grant == ID_W'(r)) begin
                sel_valid = i_req_valid[r];
                sel_inst  = i_req_inst[r*INST_W +: INST_W];
                sel_a     = i_req_data_a[r*DATA_W +: DATA_W];
                sel_b     = i_req_data_b[r*DATA_W +: DATA_W];
            end
        end
    end

    assign beat_fire   = (state == ST_ISSUE) && sel_valid && !i_alu_busy;
    assign rsp_fire    = (state == ST_WAIT) && i_alu_out_valid;
    assign rsp_is_last = (rsp_left == CNT_W'(1));

`ifdef ALU_SCHED_MAC_LOCK_EN
    logic            mac_own_vld;
    logic [ID_W-1:0] mac_own_id;
    logic            mac_rel;

    always_comb begin
        mac_rel = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (mac_own_id == ID_W'(r) && i_mac_release[r]) mac_rel = 1'b1;
        end
    end

    // A MAC request from anyone but the current owner is invisible to arbitration.
    always_comb begin
        arb_req = '0;
        for (int r = 0; r < N_REQ; r++) begin
            arb_req[r] = i_req_valid[r] &&
                         !((i_req_inst[r*INST_W +: INST_W] == INST_W'(OP_MAC)) &&
                           mac_own_vld && (mac_own_id != ID_W'(r)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mac_own_vld <= 1'b0;
            mac_own_id  <= '0;
        end else if (mac_own_vld && mac_rel) begin
            mac_own_vld <= 1'b0;
        end else if (!mac_own_vld && beat_fire && (beat_left == '0) &&
                     (sel_inst == INST_W'(OP_MAC))) begin
            mac_own_vld <= 1'b1;
            mac_own_id  <= grant;
        end
    end
`else
    assign arb_req = i_req_valid;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (rr_ptr),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_ARB;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        o_alu_in_valid = 1'b0;
        o_req_ready    = '0;
        o_alu_inst     = '0;
        o_alu_data_a   = '0;
        o_alu_data_b   = '0;
        case (state)
            ST_ARB: begin
                if (arb_vld) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                o_alu_in_valid = beat_fire;
                o_alu_inst     = (beat_left != '0) ? INST_W'(OP_MAT) : sel_inst;
                o_alu_data_a   = sel_a;
                o_alu_data_b   = sel_b;
                for (int r = 0; r < N_REQ; r++) begin
                    if (grant == ID_W'(r)) o_req_ready[r] = beat_fire;
                end
                if (beat_fire) begin
                    if (beat_left == '0) begin
                        if ((sel_inst != INST_W'(OP_MAT)) || (MAT_BEATS == 1)) state_nxt = ST_WAIT;
                    end else if (beat_left == CNT_W'(1)) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (rsp_fire && rsp_is_last) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant       <= '0;
            rr_ptr      <= '0;
            beat_left   <= '0;
            rsp_left    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_rsp_data  <= '0;
            o_rsp_last  <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_rsp_last  <= 1'b0;
            if ((state == ST_ARB) && arb_vld) grant <= arb_idx;
            if (beat_fire) begin
                if (beat_left == '0) begin
                    if (sel_inst == INST_W'(OP_MAT)) begin
                        beat_left <= CNT_W'(MAT_BEATS - 1);
                        rsp_left  <= CNT_W'(MAT_BEATS);
                    end else begin
                        rsp_left  <= CNT_W'(1);
                    end
                end else begin
                    beat_left <= beat_left - 1'b1;
                end
            end
            if (rsp_fire) begin
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= grant;
                o_rsp_data  <= i_alu_data;
                o_rsp_last  <= rsp_is_last;
                rsp_left    <= rsp_left - 1'b1;
                if (rsp_is_last) rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;

    localparam int N  = 3;
    localparam int NB = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    o_req_ready;
    logic [N*4-1:0]  i_req_inst;
    logic [N*16-1:0] i_req_data_a;
    logic [N*16-1:0] i_req_data_b;
`ifdef ALU_SCHED_MAC_LOCK_EN
    logic [N-1:0]    i_mac_release;
`endif
    logic            o_alu_in_valid;
    logic [3:0]      o_alu_inst;
    logic [15:0]     o_alu_data_a;
    logic [15:0]     o_alu_data_b;
    logic            i_alu_busy;
    logic            i_alu_out_valid;
    logic [15:0]     i_alu_data;
    logic            o_rsp_valid;
    logic [2:0]      o_rsp_id;
    logic [15:0]     o_rsp_data;
    logic            o_rsp_last;

    alu_req_scheduler #(.N_REQ(N), .ID_W(3)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_inst      (i_req_inst),
        .i_req_data_a    (i_req_data_a),
        .i_req_data_b    (i_req_data_b),
`ifdef ALU_SCHED_MAC_LOCK_EN
        .i_mac_release   (i_mac_release),
`endif
        .o_alu_in_valid  (o_alu_in_valid),
        .o_alu_inst      (o_alu_inst),
        .o_alu_data_a    (o_alu_data_a),
        .o_alu_data_b    (o_alu_data_b),
        .i_alu_busy      (i_alu_busy),
        .i_alu_out_valid (i_alu_out_valid),
        .i_alu_data      (i_alu_data),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_id        (o_rsp_id),
        .o_rsp_data      (o_rsp_data),
        .o_rsp_last      (o_rsp_last)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        bit          last;
    } rsp_t;

    // requester-side operations
    bit          op_act [N];
    logic [3:0]  op_inst[N];
    int          op_nb  [N];
    logic [15:0] op_a   [N][NB];
    logic [15:0] op_b   [N][NB];
    int          op_beat[N];

    bit gen_en, gap_en, busy_en, spur_en, rel_en, rst_drive;
    int force_busy;

    // transaction-level reference: who owns the ALU and what it must return
    bit          m_active;
    int          m_grant, m_nb, m_acc, m_rsp_left, m_ptr;
    bit          own_vld;
    int          own_id;
    rsp_t        exp_q[$];
    logic [15:0] alu_pend[$];
    logic [15:0] alu_q[$];

    int          n_checks, n_pass;
    logic [15:0] last_rsp_data;
    int          last_rsp_id;
    int          busy_issue_cnt;
    bit          ready1_seen;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [15:0] alu_fn(logic [3:0] inst, logic [15:0] a, logic [15:0] b);
        case (inst)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a ^ {b[7:0], b[15:8]} ^ {12'h0, inst};
        endcase
    endfunction

    function automatic int pick(logic [N-1:0] e, int p);
        for (int i = 0; i < N; i++) begin
            int r;
            r = (p + i) % N;
            if (e[r]) return r;
        end
        return -1;
    endfunction

    task automatic load_op(int r, logic [3:0] inst);
        op_inst[r] = inst;
        op_nb[r]   = (inst == 4'd9) ? NB : 1;
        for (int k = 0; k < NB; k++) begin
            op_a[r][k] = 16'($urandom);
            op_b[r][k] = 16'($urandom);
        end
        op_beat[r] = 0;
        op_act[r]  = 1'b1;
    endtask

    function automatic logic [3:0] rand_inst();
        case ($urandom % 6)
            0:       return 4'd0;
            1:       return 4'd1;
            2:       return 4'd2;
            3:       return 4'd9;
            default: return 4'($urandom % 16);
        endcase
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_ptr = 0; m_acc = 0; m_nb = 0; m_rsp_left = 0;
        own_vld = 1'b0; own_id = 0;
        exp_q.delete(); alu_pend.delete(); alu_q.delete();
        for (int r = 0; r < N; r++) op_act[r] = 1'b0;
    endtask

    task automatic cycle();
        logic [N-1:0] vld, elig;
        logic [N-1:0] rel;
        bit   busy, ov, wait_ph, exp_issue, exp_inv, pre_active, pre_own, rsp_v;
        rsp_t rsp_e;
        int   g, bi;

        @(negedge i_clk);
        i_rst = rst_drive;
        for (int r = 0; r < N; r++) begin
            bi = op_act[r] ? op_beat[r] : 0;
            vld[r] = op_act[r] && !(gap_en && ($urandom % 8 == 0));
            i_req_inst[r*4 +: 4]    = (op_act[r] && op_beat[r] > 0) ? 4'($urandom) : op_inst[r];
            i_req_data_a[r*16 +: 16] = op_a[r][bi];
            i_req_data_b[r*16 +: 16] = op_b[r][bi];
        end
        i_req_valid = vld;
        busy = (force_busy > 0) || (busy_en && ($urandom % 4 == 0));
        i_alu_busy = busy;
        wait_ph = m_active && (m_acc == m_nb);
        ov = 1'b0;
        i_alu_data = 16'($urandom);
        if (wait_ph && alu_q.size() > 0 && ($urandom % 3 != 0)) begin
            ov = 1'b1;
            i_alu_data = alu_q[0];
        end else if (!wait_ph && spur_en && ($urandom % 8 == 0)) begin
            ov = 1'b1;
        end
        i_alu_out_valid = ov;
        rel = '0;
        for (int r = 0; r < N; r++) rel[r] = rel_en && ($urandom % 12 == 0);
`ifdef ALU_SCHED_MAC_LOCK_EN
        i_mac_release = rel;
`endif
        #1;
        exp_issue = m_active && (m_acc < m_nb);
        exp_inv   = exp_issue && vld[m_grant] && !busy;
        rsp_v     = 1'b0;
        if (o_req_ready[1]) ready1_seen = 1'b1;
        if (!rst_drive) begin
            check("alu_in_valid", o_alu_in_valid, exp_inv);
            check("req_ready", o_req_ready, exp_inv ? (1 << m_grant) : 0);
            if (exp_inv) begin
                check("alu_inst", o_alu_inst, (m_acc == 0) ? op_inst[m_grant] : 4'd9);
                check("alu_data_a", o_alu_data_a, op_a[m_grant][m_acc]);
                check("alu_data_b", o_alu_data_b, op_b[m_grant][m_acc]);
            end else if (!exp_issue) begin
                check("alu_idle_inst", o_alu_inst, 0);
                check("alu_idle_data", {o_alu_data_a, o_alu_data_b}, 0);
            end
            if (exp_issue && busy) busy_issue_cnt++;

            pre_active = m_active;
            pre_own    = own_vld;
            if (ov && wait_ph) begin
                void'(alu_q.pop_front());
                if (exp_q.size() > 0) begin
                    rsp_e = exp_q.pop_front();
                    rsp_v = 1'b1;
                end
                m_rsp_left--;
                if (m_rsp_left == 0) begin
                    m_active = 1'b0;
                    m_ptr = (m_grant + 1) % N;
                end
            end
            if (exp_inv) begin
                alu_pend.push_back(alu_fn(o_alu_inst, o_alu_data_a, o_alu_data_b));
`ifdef ALU_SCHED_MAC_LOCK_EN
                if (m_acc == 0 && op_inst[m_grant] == 4'd2 && !pre_own) begin
                    own_vld = 1'b1;
                    own_id  = m_grant;
                end
`endif
                m_acc++;
                op_beat[m_grant]++;
                if (m_acc == m_nb) begin
                    alu_q = alu_pend;
                    alu_pend.delete();
                    op_act[m_grant] = 1'b0;
                end
            end
`ifdef ALU_SCHED_MAC_LOCK_EN
            if (pre_own && rel[own_id]) own_vld = 1'b0;
`endif
            if (!pre_active) begin
                for (int r = 0; r < N; r++) begin
                    elig[r] = vld[r];
`ifdef ALU_SCHED_MAC_LOCK_EN
                    if (i_req_inst[r*4 +: 4] == 4'd2 && pre_own && own_id != r) elig[r] = 1'b0;
`endif
                end
                g = pick(elig, m_ptr);
                if (g >= 0) begin
                    m_active = 1'b1; m_grant = g; m_nb = op_nb[g]; m_acc = 0; m_rsp_left = op_nb[g];
                    for (int k = 0; k < op_nb[g]; k++)
                        exp_q.push_back('{g, alu_fn((k == 0) ? op_inst[g] : 4'd9, op_a[g][k], op_b[g][k]),
                                          (k == op_nb[g] - 1)});
                end
            end
        end

        @(posedge i_clk);
        #1;
        if (rst_drive) begin
            model_reset();
            check("rst_rsp_valid", o_rsp_valid, 0);
            check("rst_rsp_last", o_rsp_last, 0);
            check("rst_rsp_id", o_rsp_id, 0);
            check("rst_rsp_data", o_rsp_data, 0);
        end else if (rsp_v) begin
            check("rsp_valid", o_rsp_valid, 1);
            check("rsp_id", o_rsp_id, rsp_e.id);
            check("rsp_data", o_rsp_data, rsp_e.data);
            check("rsp_last", o_rsp_last, rsp_e.last);
            last_rsp_data = o_rsp_data;
            last_rsp_id   = o_rsp_id;
        end else begin
            check("rsp_valid_idle", o_rsp_valid, 0);
        end
        if (force_busy > 0) force_busy--;
        if (gen_en)
            for (int r = 0; r < N; r++)
                if (!op_act[r] && ($urandom % 4 == 0)) load_op(r, rand_inst());
    endtask

    function automatic bit any_op();
        for (int r = 0; r < N; r++) if (op_act[r]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(string tag);
        int n;
        n = 0;
        while ((m_active || any_op()) && n < 3000) begin
            cycle();
            n++;
        end
        check(tag, n < 3000, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0; n_pass = 0;
        i_rst = 1'b1; i_req_valid = '0; i_req_inst = '0; i_req_data_a = '0; i_req_data_b = '0;
        i_alu_busy = 1'b0; i_alu_out_valid = 1'b0; i_alu_data = '0;
`ifdef ALU_SCHED_MAC_LOCK_EN
        i_mac_release = '0;
`endif
        gen_en = 0; gap_en = 0; busy_en = 0; spur_en = 0; rel_en = 0; force_busy = 0;
        busy_issue_cnt = 0; ready1_seen = 0; last_rsp_id = -1; last_rsp_data = '0;
        for (int r = 0; r < N; r++) begin
            op_inst[r] = '0; op_nb[r] = 1; op_beat[r] = 0;
            for (int k = 0; k < NB; k++) begin op_a[r][k] = '0; op_b[r][k] = '0; end
        end
        model_reset();

        rst_drive = 1'b1;
        repeat (3) cycle();
        rst_drive = 1'b0;
        repeat (2) cycle();

        // single ADD 1.0 + 3.0 from requester 0
        load_op(0, 4'd0);
        op_a[0][0] = 16'h0400;
        op_b[0][0] = 16'h0C00;
        drain("single_add_done");
        check("single_add_data", last_rsp_data, 16'h1000);
        check("single_add_id", last_rsp_id, 0);

        // matrix burst on req1 while req0 waits with an ADD
        load_op(1, 4'd9);
        load_op(0, 4'd0);
        drain("matrix_contention_done");

        // ALU busy held during issue
        busy_issue_cnt = 0;
        load_op(2, 4'd1);
        force_busy = 7;
        drain("busy_hold_done");
        check("busy_hold_cycles", busy_issue_cnt >= 5, 1);

        // randomized traffic
        gen_en = 1; gap_en = 1; busy_en = 1; spur_en = 1; rel_en = 1;
        repeat (3000) cycle();
        gen_en = 0;
        drain("random_drain_done");
        gap_en = 0; busy_en = 0; rel_en = 0;

`ifdef ALU_SCHED_MAC_LOCK_EN
        // drain leaves the owner whatever releases left it; start from a clean owner
        rst_drive = 1'b1; cycle(); rst_drive = 1'b0;
        load_op(0, 4'd2);
        drain("mac_owner_done");
        ready1_seen = 1'b0;
        load_op(1, 4'd2);
        repeat (30) cycle();
        check("mac_lock_blocks", ready1_seen, 0);
        rel_en = 1;
        drain("mac_release_done");
        rel_en = 0;
`endif

        // reset in the middle of a matrix burst
        load_op(1, 4'd9);
        n = 0;
        while (op_beat[1] < 3 && n < 200) begin cycle(); n++; end
        check("mid_burst_reached", n < 200, 1);
        spur_en = 0;
        rst_drive = 1'b1;
        cycle();
        rst_drive = 1'b0;
        repeat (3) cycle();
        load_op(1, 4'd0);
        drain("post_reset_done");
        check("post_reset_id", last_rsp_id, 1);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
